// File: rtl/powlib_ipmemtest_pkg.sv
// Shared opcodes, FSM encoding and packet offsets for the PLB memory tester.
// Optional watchdog build switch: POWLIB_MEMTEST_TIMEOUT_EN.
`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef POWLIB_OPW
`define POWLIB_OPW 4
`endif

package powlib_memtest_pkg;

    localparam int BW  = `POWLIB_BW;
    localparam int OPW = `POWLIB_OPW;

    localparam logic [OPW-1:0] OP_WRITE = '0;
    localparam logic [OPW-1:0] OP_READ  = OPW'(1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        DONE
    } state_t;

    // packet layout is {op, be, data}, data in the low bits
    function automatic int be_lsb(int bpd);
        return bpd * BW;
    endfunction

    function automatic int op_lsb(int bpd);
        return bpd * BW + bpd;
    endfunction

endpackage

// File: rtl/powlib_ipmemtest_if.sv
// Request/response PLB channel pair between the memory tester and the crossbar.
// Optional watchdog build switch: POWLIB_MEMTEST_TIMEOUT_EN.
interface powlib_ipmemtest_if #(
    parameter int B_AW = 4 * `POWLIB_BW,
    parameter int B_PW = 4 * `POWLIB_BW + 4 + `POWLIB_OPW
);
    logic [B_AW-1:0] rdaddr;
    logic [B_PW-1:0] rddata;
    logic            rdvld;
    logic            rdrdy;
    logic [B_AW-1:0] wraddr;
    logic [B_PW-1:0] wrdata;
    logic            wrvld;
    logic            wrrdy;

    modport master (
        output rdaddr, rddata, rdvld, wrrdy,
        input  rdrdy, wraddr, wrdata, wrvld
    );

    modport slave (
        input  rdaddr, rddata, rdvld, wrrdy,
        output rdrdy, wraddr, wrdata, wrvld
    );
endinterface

// File: rtl/powlib_ipmemtest_chk.sv
// Response checker: decodes word index, compares against the pattern,
// keeps a saturating error count and the in-range return count.
module powlib_memtest_chk
    import powlib_memtest_pkg::*;
#(
    parameter              ID     = "MEMTEST",
    parameter int          EDBG   = 0,
    parameter int          B_BPD  = 4,
    parameter int          B_AW   = 32,
    parameter int          B_DW   = 32,
    parameter logic [B_AW-1:0] B_BASE = '0,
    parameter int          WORDS  = 256,
    parameter logic [31:0] SEED   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            active,
    input  logic            hit,
    input  logic [B_AW-1:0] addr,
    input  logic [B_DW-1:0] data,
    input  logic [OPW-1:0]  op,
    output logic [15:0]     errcnt,
    output logic [16:0]     retcnt
);

    localparam int SH = $clog2(B_BPD);

    logic [B_AW-1:0] off;
    logic [B_AW-1:0] k;
    logic [B_DW-1:0] exp_d;
    logic            in_rng;
    logic            bad;

    always_comb begin
        off    = addr - B_BASE;
        k      = off >> SH;
        in_rng = k < B_AW'(WORDS);
        exp_d  = B_DW'(SEED) ^ B_DW'(k);
        // outside a run every response is stray
        bad    = !active || !in_rng || (data != exp_d) || (op != OP_WRITE);
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            errcnt <= '0;
            retcnt <= '0;
        end else if (hit) begin
            if (bad && errcnt != 16'hFFFF)
                errcnt <= errcnt + 16'd1;
            if (active && in_rng)
                retcnt <= retcnt + 17'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (EDBG != 0 && rst && hit && bad)
            $info("%s: resp %h word %0d data %h exp %h",
                  ID, addr, k, data, exp_d);
    end

endmodule

// File: rtl/powlib_ipmemtest.sv
// PLB memory tester: writes SEED^i over WORDS words, reads them back, checks.
// Optional watchdog in WAIT (adds timeout port): POWLIB_MEMTEST_TIMEOUT_EN.
module powlib_ipmemtest
    import powlib_memtest_pkg::*;
#(
    parameter              ID     = "MEMTEST",
    parameter int          EAR    = 0,
    parameter int          EDBG   = 0,
    parameter int          B_BPD  = 4,
    parameter int          B_AW   = `POWLIB_BW * B_BPD,
    parameter logic [B_AW-1:0] B_BASE = 32'h50000000,
    parameter logic [B_AW-1:0] T_BASE = 32'h44A00000,
    parameter int          WORDS  = 256,
    parameter logic [31:0] SEED   = 32'hA5A50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] errcnt,
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
    output logic        timeout,
`endif
    powlib_ipmemtest_if.master bus
);

    localparam int B_DW   = B_BPD * BW;
    localparam int B_PW   = B_DW + B_BPD + OPW;
    localparam int SH     = $clog2(B_BPD);
    localparam int BE_LSB = be_lsb(B_BPD);
    localparam int OP_LSB = op_lsb(B_BPD);
    localparam logic [B_BPD-1:0] BE_ALL = '1;

    state_t          st;
    logic [15:0]     idx;
    logic            q_vld;
    logic            q_rdy;
    logic [B_AW-1:0] q_addr;
    logic [B_PW-1:0] q_data;
    logic            s_busy;
    logic            s_done;
    logic            s_pass;
    logic [15:0]     err_q;
    logic [16:0]     ret_q;
    logic            acc;
    logic            last;
    logic            clr;
    logic            active;
    logic            hit;
    logic            unused_be;
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
    logic [19:0]     wdog;
    logic            s_tmo;
`endif

    function automatic logic [B_AW-1:0] taddr(logic [15:0] i);
        return T_BASE + (B_AW'(i) << SH);
    endfunction

    function automatic logic [B_PW-1:0] wpkt(logic [15:0] i);
        return {OP_WRITE, BE_ALL, B_DW'(SEED) ^ B_DW'(i)};
    endfunction

    // read payload carries the address the RAM returns data to
    function automatic logic [B_PW-1:0] rpkt(logic [15:0] i);
        return {OP_READ, BE_ALL, B_DW'(B_BASE + (B_AW'(i) << SH))};
    endfunction

    assign acc       = q_vld && q_rdy;
    assign last      = idx == 16'(WORDS - 1);
    assign clr       = start && (st == IDLE || st == DONE);
    assign active    = st == WRITE || st == READ || st == WAIT;
    assign bus.wrrdy = 1'b1;
    assign hit       = bus.wrvld && bus.wrrdy;
    assign unused_be = ^bus.wrdata[BE_LSB +: B_BPD];

    always_ff @(posedge clk) begin
        if (!rst) begin
            st     <= IDLE;
            idx    <= '0;
            q_vld  <= 1'b0;
            q_addr <= '0;
            q_data <= '0;
            s_busy <= 1'b0;
            s_done <= 1'b0;
            s_pass <= 1'b0;
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
            wdog   <= '0;
            s_tmo  <= 1'b0;
`endif
        end else begin
            unique case (st)
                IDLE, DONE: if (start) begin
                    st     <= WRITE;
                    idx    <= '0;
                    q_vld  <= 1'b1;
                    q_addr <= taddr(16'd0);
                    q_data <= wpkt(16'd0);
                    s_busy <= 1'b1;
                    s_done <= 1'b0;
                    s_pass <= 1'b0;
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
                    s_tmo  <= 1'b0;
`endif
                end
                WRITE: if (acc) begin
                    if (last) begin
                        st     <= READ;
                        idx    <= '0;
                        q_addr <= taddr(16'd0);
                        q_data <= rpkt(16'd0);
                    end else begin
                        idx    <= idx + 16'd1;
                        q_addr <= taddr(idx + 16'd1);
                        q_data <= wpkt(idx + 16'd1);
                    end
                end
                READ: if (acc) begin
                    if (last) begin
                        st    <= WAIT;
                        q_vld <= 1'b0;
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
                        wdog  <= '0;
`endif
                    end else begin
                        idx    <= idx + 16'd1;
                        q_addr <= taddr(idx + 16'd1);
                        q_data <= rpkt(idx + 16'd1);
                    end
                end
                WAIT: begin
                    if (ret_q == 17'(WORDS)) begin
                        st     <= DONE;
                        s_busy <= 1'b0;
                        s_done <= 1'b1;
                        s_pass <= err_q == 16'd0;
                    end
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
                    else if (wdog == '1) begin
                        st     <= DONE;
                        s_busy <= 1'b0;
                        s_done <= 1'b1;
                        s_pass <= 1'b0;
                        s_tmo  <= 1'b1;
                    end
                    wdog <= hit ? '0 : wdog + 20'd1;
`endif
                end
                default: st <= IDLE;
            endcase
        end
    end

    powlib_memtest_chk #(
        .ID(ID), .EDBG(EDBG), .B_BPD(B_BPD), .B_AW(B_AW), .B_DW(B_DW),
        .B_BASE(B_BASE), .WORDS(WORDS), .SEED(SEED)
    ) u_chk (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .active(active),
        .hit(hit),
        .addr(bus.wraddr),
        .data(bus.wrdata[B_DW-1:0]),
        .op(bus.wrdata[OP_LSB +: OPW]),
        .errcnt(err_q),
        .retcnt(ret_q)
    );

    generate
        if (EAR != 0) begin : g_ear
            logic            o_vld;
            logic [B_AW-1:0] o_addr;
            logic [B_PW-1:0] o_data;

            // one-entry pipeline stage: refills whenever empty or draining
            assign q_rdy      = !o_vld || bus.rdrdy;
            assign bus.rdvld  = o_vld;
            assign bus.rdaddr = o_addr;
            assign bus.rddata = o_data;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    o_vld   <= 1'b0;
                    o_addr  <= '0;
                    o_data  <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                    errcnt  <= '0;
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
                    timeout <= 1'b0;
`endif
                end else begin
                    if (q_rdy) begin
                        o_vld  <= q_vld;
                        o_addr <= q_addr;
                        o_data <= q_data;
                    end
                    busy    <= s_busy;
                    done    <= s_done;
                    pass    <= s_pass;
                    errcnt  <= err_q;
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
                    timeout <= s_tmo;
`endif
                end
            end
        end else begin : g_dir
            assign q_rdy      = bus.rdrdy;
            assign bus.rdvld  = q_vld;
            assign bus.rdaddr = q_addr;
            assign bus.rddata = q_data;
            assign busy       = s_busy;
            assign done       = s_done;
            assign pass       = s_pass;
            assign errcnt     = err_q;
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
            assign timeout    = s_tmo;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_powlib_ipmemtest.sv
// Directed bench for powlib_ipmemtest against a small RAM model.
// Watchdog scenario only with POWLIB_MEMTEST_TIMEOUT_EN.
module tb_powlib_ipmemtest;
    import powlib_memtest_pkg::*;

    localparam int W   = 4;
    localparam int PW  = 32 + 4 + OPW;
    localparam int OPL = 36;
    localparam logic [31:0] TB = 32'h44A00000;
    localparam logic [31:0] BB = 32'h50000000;
    localparam logic [31:0] SD = 32'hA5A50000;

    typedef struct packed {
        logic [31:0]   a;
        logic [PW-1:0] d;
    } req_t;

    typedef struct packed {
        logic [31:0]   a;
        logic [PW-1:0] d;
        logic [31:0]   due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] errcnt;
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
    logic        timeout;
`endif

    powlib_ipmemtest_if #(.B_AW(32), .B_PW(PW)) bus ();

    powlib_ipmemtest #(
        .B_BASE(BB), .T_BASE(TB), .WORDS(W), .SEED(SD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .pass(pass),
        .errcnt(errcnt),
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
        .timeout(timeout),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    req_t        exp_q[$];
    rsp_t        rsp_q[$];
    rsp_t        hold_q[$];
    logic [31:0] mem [0:W-1];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          mode = 0;
    bit          rnd_rdy = 1'b0;
    int          n_wr = 0;
    int          n_rd = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp();
        req_t e;
        exp_q.delete();
        for (int i = 0; i < W; i++) begin
            e.a = TB + 32'(i * 4);
            e.d = {OP_WRITE, 4'hF, SD ^ 32'(i)};
            exp_q.push_back(e);
        end
        for (int i = 0; i < W; i++) begin
            e.a = TB + 32'(i * 4);
            e.d = {OP_READ, 4'hF, BB + 32'(i * 4)};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(int lim);
        int n = 0;
        while (!done && n < lim) begin
            tick();
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic run_test(int m, bit r, int lim,
                            logic [15:0] e_err, logic e_pass);
        mode = m;
        rnd_rdy = r;
        n_wr = 0;
        n_rd = 0;
        push_exp();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rdvld_lat", bus.rdvld, 1);
        chk("busy_on", busy, 1);
        chk("done_clr", done, 0);
        wait_done(lim);
        chk("errcnt", errcnt, e_err);
        chk("pass", pass, e_pass);
        chk("busy_off", busy, 0);
        chk("req_left", exp_q.size(), 0);
        chk("n_wr", n_wr, W);
        chk("n_rd", n_rd, W);
    endtask

    // RAM model and request scoreboard, acting half a cycle off the DUT edge
    initial begin
        rsp_t          r;
        req_t          e;
        logic [31:0]   w;
        logic [31:0]   d;
        logic [31:0]   p_a;
        logic [PW-1:0] p_d;
        bit            prev_stall;
        prev_stall = 1'b0;
        p_a = '0;
        p_d = '0;
        bus.rdrdy = 1'b0;
        bus.wrvld = 1'b0;
        bus.wraddr = '0;
        bus.wrdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rsp_q.size() > 0 && rsp_q[0].due <= 32'(cyc)) begin
                r = rsp_q.pop_front();
                bus.wrvld = 1'b1;
                bus.wraddr = r.a;
                bus.wrdata = r.d;
            end else begin
                bus.wrvld = 1'b0;
            end
            bus.rdrdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && rst) begin
                chk("stall_addr", bus.rdaddr, p_a);
                chk("stall_data", bus.rddata, p_d);
            end
            prev_stall = rst && bus.rdvld && !bus.rdrdy;
            p_a = bus.rdaddr;
            p_d = bus.rddata;
            if (rst && bus.rdvld && bus.rdrdy) begin
                chk("req_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("req_addr", bus.rdaddr, e.a);
                    chk("req_data", bus.rddata, e.d);
                end
                w = (bus.rdaddr - TB) >> 2;
                if (w < W) begin
                    if (bus.rddata[OPL +: OPW] == OP_WRITE) begin
                        n_wr++;
                        mem[w] = bus.rddata[31:0];
                    end else begin
                        n_rd++;
                        d = mem[w];
                        if (mode == 1 && w == 2)
                            d = 32'h0;
                        r = '{a: bus.rddata[31:0], d: {OP_WRITE, 4'hF, d},
                              due: 32'(cyc + 2)};
                        if (mode == 2) begin
                            hold_q.push_back(r);
                            if (hold_q.size() == W) begin
                                while (hold_q.size() > 0) begin
                                    r = hold_q.pop_back();
                                    r.due = 32'(cyc + 2);
                                    rsp_q.push_back(r);
                                end
                            end
                        end else if (!(mode == 3 && w == 1)) begin
                            rsp_q.push_back(r);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rsp_t s;
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_errcnt", errcnt, 0);
        chk("rst_rdvld", bus.rdvld, 0);
        chk("rst_wrrdy", bus.wrrdy, 1);
        rst = 1'b1;
        tick();

        run_test(0, 1'b0, 200, 16'd0, 1'b1);
`ifdef POWLIB_MEMTEST_TIMEOUT_EN
        chk("tmo_clear", timeout, 0);
`endif
        run_test(1, 1'b0, 200, 16'd1, 1'b0);
        run_test(0, 1'b1, 400, 16'd0, 1'b1);
        run_test(2, 1'b0, 200, 16'd0, 1'b1);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        s = '{a: BB + 32'h40, d: {OP_WRITE, 4'hF, 32'h0}, due: 32'(cyc)};
        rsp_q.push_back(s);
        repeat (5) tick();
        chk("stray_err", errcnt, 1);
        chk("stray_busy", busy, 0);
        run_test(0, 1'b0, 200, 16'd0, 1'b1);

        mode = 0;
        rnd_rdy = 1'b0;
        push_exp();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(bus.rdvld && bus.rddata[OPL +: OPW] == OP_READ) && n < 50) begin
            tick();
            n++;
        end
        chk("reach_read", bus.rddata[OPL +: OPW], OP_READ);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_rdvld", bus.rdvld, 0);
        chk("midrst_done", done, 0);
        rst = 1'b1;
        exp_q.delete();
        repeat (10) tick();
        chk("midrst_stray", errcnt, 1);
        run_test(0, 1'b0, 200, 16'd0, 1'b1);

`ifdef POWLIB_MEMTEST_TIMEOUT_EN
        run_test(3, 1'b0, 1100000, 16'd0, 1'b0);
        chk("tmo_set", timeout, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
